// File: rtl/sta_trfi_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// sta_trfi_frame_ctrl_if
// Bundles every non-clock/non-reset signal of the STA_TRFI frame controller.
//   slave  : controller view (drives s_TREADY, m_*, rm_modType, result*, busy,
//            timeout_err, dfx_decouple, rm_rst_n)
//   master : environment view (upstream source, estimator, DFX manager)
// ---------------------------------------------------------------------------
interface sta_trfi_frame_ctrl_if;
  logic [31:0] cfg_modType;
  logic        frame_start;
  logic [63:0] s_TDATA;
  logic        s_TVALID;
  logic        s_TREADY;
  logic [63:0] m_TDATA;
  logic        m_TVALID;
  logic        m_TREADY;
  logic        m_TLAST;
  logic [31:0] rm_modType;
  logic        est_TVALID;
  logic        est_TREADY;
  logic        est_TLAST;
  logic [31:0] rm_ap_return;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic        timeout_err;
  logic        dfx_req;
  logic        dfx_decouple;
  logic        dfx_done;
  logic        rm_rst_n;

  modport slave (
    input  cfg_modType, frame_start, s_TDATA, s_TVALID, m_TREADY,
           est_TVALID, est_TREADY, est_TLAST, rm_ap_return, dfx_req, dfx_done,
    output s_TREADY, m_TDATA, m_TVALID, m_TLAST, rm_modType, result,
           result_valid, busy, timeout_err, dfx_decouple, rm_rst_n
  );

  modport master (
    output cfg_modType, frame_start, s_TDATA, s_TVALID, m_TREADY,
           est_TVALID, est_TREADY, est_TLAST, rm_ap_return, dfx_req, dfx_done,
    input  s_TREADY, m_TDATA, m_TVALID, m_TLAST, rm_modType, result,
           result_valid, busy, timeout_err, dfx_decouple, rm_rst_n
  );
endinterface

// File: rtl/sta_trfi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// sta_trfi_frame_ctrl
// Frame sequencer / DFX controller for the STA_TRFI channel-estimator RP.
// Gates one frame of 64-bit words into the estimator, generates its TLAST,
// latches modType per frame, captures ap_return after the estimate stream
// ends, and holds partial-reconfiguration requests until no frame is active.
//
// Ports:
//   ap_clk    : clock (single domain)
//   ap_rst_n  : synchronous active-low reset
//   bus       : sta_trfi_frame_ctrl_if.slave (streams, result, DFX handshake)
//
// Build option: define STA_TRFI_TIMEOUT_EN to enable the WAIT_EST watchdog.
// Without it WAIT_EST waits indefinitely and timeout_err is tied low.
// ---------------------------------------------------------------------------
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no frame; accepts frame_start or services a DFX request
// FEED     | words pass through to the estimator, counted for TLAST
// WAIT_EST | frame sent, waiting for the estimate stream's last beat
// DECOUPLE | RP isolated and held in reset until dfx_done
// RM_RESET | RP still held in reset for RST_HOLD cycles after dfx_done
// ---------------------------------------------------------------------------
module sta_trfi_frame_ctrl #(
  parameter int unsigned WORDS_PER_FRAME = 104,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter int unsigned RST_HOLD        = 16
) (
  input logic                  ap_clk,
  input logic                  ap_rst_n,
  sta_trfi_frame_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RH_W  = $clog2(RST_HOLD + 1);

`ifdef STA_TRFI_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_FRAME - 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RH_W-1:0]  RH_LOAD  = RH_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FEED     = 3'd1,
    WAIT_EST = 3'd2,
    DECOUPLE = 3'd3,
    RM_RESET = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WD_W-1:0]  wd_cnt_q;
  logic [RH_W-1:0]  rh_cnt_q;
  logic             est_seen_q;
  logic             dfx_pending_q;
  logic [31:0]      modtype_q;
  logic [31:0]      result_q;
  logic             result_valid_q;
  logic             timeout_err_q;
  logic             decouple_q;
  logic             rm_rst_n_q;

  logic feed_act;
  logic in_hs;
  logic est_last_hs;

  // Gating with ap_rst_n drops the pass-through in the very cycle reset is
  // asserted, before the synchronous reset reaches state_q.
  assign feed_act    = (state_q == FEED) && ap_rst_n;
  assign in_hs       = bus.m_TVALID && bus.m_TREADY;
  assign est_last_hs = bus.est_TVALID && bus.est_TREADY && bus.est_TLAST;

  assign bus.m_TDATA      = feed_act ? bus.s_TDATA : '0;
  assign bus.m_TVALID     = feed_act && bus.s_TVALID;
  assign bus.s_TREADY     = feed_act && bus.m_TREADY;
  assign bus.m_TLAST      = feed_act && (cnt_q == LAST_IDX);
  assign bus.rm_modType   = modtype_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.timeout_err  = WD_EN ? timeout_err_q : 1'b0;
  assign bus.dfx_decouple = decouple_q;
  assign bus.rm_rst_n     = rm_rst_n_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      wd_cnt_q       <= '0;
      rh_cnt_q       <= '0;
      est_seen_q     <= 1'b0;
      dfx_pending_q  <= 1'b0;
      modtype_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      decouple_q     <= 1'b0;
      rm_rst_n_q     <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rm_rst_n_q <= 1'b1;
          // A DFX request wins over a simultaneous frame_start.
          if (bus.dfx_req || dfx_pending_q) begin
            state_q    <= DECOUPLE;
            decouple_q <= 1'b1;
            rm_rst_n_q <= 1'b0;
          end else if (bus.frame_start) begin
            modtype_q  <= bus.cfg_modType;
            cnt_q      <= '0;
            est_seen_q <= 1'b0;
            state_q    <= FEED;
          end
        end
        FEED: begin
          if (bus.dfx_req) dfx_pending_q <= 1'b1;
          if (est_last_hs) est_seen_q <= 1'b1;
          if (in_hs) begin
            if (cnt_q == LAST_IDX) begin
              state_q  <= WAIT_EST;
              wd_cnt_q <= WD_LOAD;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        WAIT_EST: begin
          if (bus.dfx_req) dfx_pending_q <= 1'b1;
          if (est_seen_q || est_last_hs) begin
            result_q       <= bus.rm_ap_return;
            result_valid_q <= 1'b1;
            state_q        <= IDLE;
          end else if (WD_EN && (wd_cnt_q == '0)) begin
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_q - WD_W'(1);
          end
        end
        DECOUPLE: begin
          if (bus.dfx_done) begin
            dfx_pending_q <= 1'b0;
            rh_cnt_q      <= RH_LOAD;
            state_q       <= RM_RESET;
          end
        end
        RM_RESET: begin
          if (rh_cnt_q == '0) begin
            state_q    <= IDLE;
            decouple_q <= 1'b0;
            rm_rst_n_q <= 1'b1;
          end else begin
            rh_cnt_q <= rh_cnt_q - RH_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
